// File: rtl/regfile_mp.sv
// Multi-port register file: 2 combinational read ports, 2 write ports (B wins on collision),
// optional write-to-read bypass, optional hardwired zero register and a per-register busy scoreboard.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              wa_en,
    input  logic [ADDR_W-1:0] wa_addr,
    input  logic [DATA_W-1:0] wa_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              busy_set,
    input  logic [ADDR_W-1:0] busy_addr,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              rs_busy,
    output logic              rt_busy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic              wa_ok;
    logic              wb_ok;
    logic              set_ok;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Writes to a hardwired r0 are dropped entirely: no store, no bypass, no busy clear.
    assign wa_ok  = ena && wa_en && !is_zero(wa_addr);
    assign wb_ok  = ena && wb_en && !is_zero(wb_addr);
    assign set_ok = ena && busy_set && !is_zero(busy_addr);

    // Clears first, then set, so a newly issued producer supersedes a retiring one.
    always_comb begin
        busy_nxt = busy;
        if (wa_ok) busy_nxt[wa_addr] = 1'b0;
        if (wb_ok) busy_nxt[wb_addr] = 1'b0;
        if (set_ok) busy_nxt[busy_addr] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (ena) begin
            busy <= busy_nxt;
            if (wa_ok) regs[wa_addr] <= wa_data;
            if (wb_ok) regs[wb_addr] <= wb_data;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = regs[a];
        if (BYPASS != 0) begin
            if (wa_ok && (wa_addr == a)) v = wa_data;
            if (wb_ok && (wb_addr == a)) v = wb_data;
        end
        if (is_zero(a) || !ena || rst) v = '0;
        return v;
    endfunction

    always_comb begin
        rs_data = read_port(rs_addr);
        rt_data = read_port(rt_addr);
        rs_busy = busy[rs_addr] && ena && !rst;
        rt_busy = busy[rt_addr] && ena && !rst;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port general-purpose register file, the successor to the single-write CPU register file. It provides 2 combinational read ports and 2 write ports, with optional write-to-read bypass and an optional hardwired zero register. It also keeps a per-register busy scoreboard, so the issue stage can detect RAW hazards against in-flight producers. It sits between decode (reads, busy set) and writeback (writes, busy clear).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and never becomes busy
BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous reset, active-high
ena  in  1  block enable; 0 = no state update, read data forced to 0
wa_en  in  1  write port A enable
wa_addr  in  ADDR_W  write port A address
wa_data  in  DATA_W  write port A data
wb_en  in  1  write port B enable
wb_addr  in  ADDR_W  write port B address
wb_data  in  DATA_W  write port B data
busy_set  in  1  mark busy_addr busy (instruction issued)
busy_addr  in  ADDR_W  register to mark busy
rs_addr  in  ADDR_W  read port S address
rt_addr  in  ADDR_W  read port T address
rs_data  out  DATA_W  read port S data (combinational)
rt_data  out  DATA_W  read port T data (combinational)
rs_busy  out  1  busy bit of rs_addr (combinational)
rt_busy  out  1  busy bit of rt_addr (combinational)

Behaviour:
- Reset: rst is asynchronous, active-high. It clears every register and every busy bit to 0 immediately, regardless of ena. Outputs read 0 while rst is high. A reset mid-stream discards pending writes and busy sets.
- Writes: on posedge clk, when ena=1 and wX_en=1, reg[wX_addr] <= wX_data. Write latency is 1 cycle.
- Same-address writes: if both ports write the same address in the same cycle, port B wins.
- Zero register: with ZERO_REG=1, writes to address 0 are dropped. With ZERO_REG=0, register 0 is an ordinary register.
- Reads: purely combinational with no clock latency.
  - ena=0: read data = 0.
  - ZERO_REG=1 and address 0: read data = 0.
  - BYPASS=1 and address matches an enabled write this cycle: read data = that write's data; port B takes priority over port A; no bypass from a dropped reg-0 write.
  - Otherwise: read data = stored value.
- Scoreboard:
  - Set: on posedge clk with ena=1, busy_set=1 sets busy[busy_addr].
  - Clear: any enabled write clears busy[wX_addr].
  - Set and clear on the same address in the same cycle: set wins, because a new producer supersedes the old one.
  - Address 0 is never busy when ZERO_REG=1.
  - busy_set on an already-busy register leaves it busy (no counting).
- Busy outputs: rs_busy/rt_busy = busy[addr] & ena. They are not bypassed: a clear in the current cycle shows on the next cycle.
- ena=0: all writes and busy updates are ignored; stored state is held.
- Implementation: no X propagation on any output after reset; all addresses are in range by construction.

Test Plan:
- Reset: assert rst asynchronously mid-cycle after filling r5=0xDEADBEEF -> rs_data(rs_addr=5)=0 and rs_busy=0 immediately, with no clock edge.
- Basic write and bypass: wa_en=1, wa_addr=3, wa_data=0x12345678, rs_addr=3, BYPASS=1 -> rs_data=0x12345678 in the same cycle. With BYPASS=0 -> old value (0) until after the edge, then 0x12345678.
- Dual-write collision: wa and wb both target r7 with 0xAAAA0000 and 0x0000BBBB -> r7=0x0000BBBB after the edge; rt_data bypass also 0x0000BBBB.
- Zero register: write 0xFFFFFFFF to r0 and busy_set r0 with ZERO_REG=1 -> rs_data=0 and rs_busy=0. With ZERO_REG=0 -> 0xFFFFFFFF and busy=1.
- Scoreboard: busy_set r9, then wb write r9 -> rs_busy 1 for one cycle, then 0. Same-cycle busy_set r9 plus wa write r9 -> r9 updated and busy=1.
- Enable gating: ena=0 with writes and busy_set to r4 -> r4 unchanged, busy unchanged, read data 0. Raise ena -> previous stored value visible.
